// File: rtl/note_sequencer.sv
// Record/playback controller that arbitrates the tone path between the live keypad and a recorded buffer.
// Optional macro NOTE_SEQUENCER_LOOP_EN: playback wraps to the first segment instead of ending.
module note_sequencer #(
    parameter int          DEPTH    = 16,
    parameter int          DUR_W    = 6,
    parameter logic [25:0] TICK_MAX = 26'd2_699_999
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     rec_start,
    input  logic                     play_start,
    input  logic                     stop,
    input  logic                     key_pushed,
    input  logic [3:0]               key_code,
    output logic                     out_en,
    output logic [3:0]               out_code,
    output logic [1:0]               mode,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int              AW      = $clog2(DEPTH);
    localparam int              EW      = 5 + DUR_W;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;
    localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, REC = 2'd1, PLAY = 2'd2} state_t;

    state_t           state;
    logic [25:0]      tick_cnt;
    logic [AW:0]      rd;
    logic             seg_pushed;
    logic [3:0]       seg_code;
    logic [DUR_W-1:0] seg_dur;
    logic [DUR_W-1:0] play_elapsed;
    logic [EW-1:0]    mem [DEPTH];

    logic             tick;
    logic [DUR_W-1:0] dur_next;
    logic             key_changed;
    logic             keep_seg;
    logic             wr_en;
    logic [AW:0]      count_inc;
    logic [AW:0]      rd_inc;
    logic [DUR_W-1:0] elapsed_inc;
    logic [DUR_W-1:0] rd_dur;
    logic             nx_pushed;
    logic [3:0]       nx_code;

    assign mode        = state;
    assign tick        = (state != IDLE) && (tick_cnt == TICK_MAX);
    // A tick landing on the closing cycle still belongs to the closing segment.
    assign dur_next    = seg_dur + DUR_W'(tick);
    assign key_changed = (key_pushed != seg_pushed) || (seg_pushed && (key_code != seg_code));
    // Zero-length segments are glitches; rests are only kept once a note is stored.
    assign keep_seg    = (dur_next != '0) && (seg_pushed || (count != '0));
    assign wr_en       = (state == REC) && keep_seg && !full &&
                         (stop || key_changed || (dur_next == DUR_MAX));
    assign count_inc   = count + (AW+1)'(1);
    assign rd_inc      = rd + (AW+1)'(1);
    assign elapsed_inc = play_elapsed + DUR_W'(1);
    assign rd_dur      = mem[rd[AW-1:0]][DUR_W-1:0];
    assign nx_pushed   = mem[rd_inc[AW-1:0]][EW-1];
    assign nx_code     = mem[rd_inc[AW-1:0]][EW-2 -: 4];

    always_ff @(posedge clk) begin
        if (wr_en) mem[count[AW-1:0]] <= {seg_pushed, seg_code, dur_next};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            rd           <= '0;
            seg_pushed   <= 1'b0;
            seg_code     <= '0;
            seg_dur      <= '0;
            play_elapsed <= '0;
            count        <= '0;
            full         <= 1'b0;
            out_en       <= 1'b0;
            out_code     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    out_en   <= key_pushed;
                    out_code <= key_code;
                    if (stop) begin
                        state <= IDLE;
                    end else if (rec_start) begin
                        state      <= REC;
                        count      <= '0;
                        full       <= 1'b0;
                        seg_pushed <= key_pushed;
                        seg_code   <= key_code;
                        seg_dur    <= '0;
                    end else if (play_start && (count != '0)) begin
                        state        <= PLAY;
                        rd           <= '0;
                        play_elapsed <= '0;
                        out_en       <= mem[0][EW-1];
                        out_code     <= mem[0][EW-2 -: 4];
                    end
                end
                REC: begin
                    out_en   <= key_pushed;
                    out_code <= key_code;
                    tick_cnt <= tick ? '0 : tick_cnt + 26'd1;
                    if (wr_en) count <= count_inc;
                    if (stop) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                    end else if (wr_en && (count_inc == DEPTH_C)) begin
                        full     <= 1'b1;
                        state    <= IDLE;
                        tick_cnt <= '0;
                    end else if (key_changed) begin
                        seg_pushed <= key_pushed;
                        seg_code   <= key_code;
                        seg_dur    <= '0;
                    end else if (dur_next == DUR_MAX) begin
                        seg_dur <= '0;
                    end else begin
                        seg_dur <= dur_next;
                    end
                end
                PLAY: begin
                    tick_cnt <= tick ? '0 : tick_cnt + 26'd1;
                    if (stop) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        out_en   <= key_pushed;
                        out_code <= key_code;
                    end else if (tick && (elapsed_inc == rd_dur)) begin
                        play_elapsed <= '0;
                        if (rd_inc == count) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                            rd       <= '0;
                            out_en   <= mem[0][EW-1];
                            out_code <= mem[0][EW-2 -: 4];
`else
                            state    <= IDLE;
                            tick_cnt <= '0;
                            out_en   <= key_pushed;
                            out_code <= key_code;
`endif
                        end else begin
                            rd       <= rd_inc;
                            out_en   <= nx_pushed;
                            out_code <= nx_code;
                        end
                    end else if (tick) begin
                        play_elapsed <= elapsed_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_MAX=3, DEPTH=4, DUR_W=3.
module tb_note_sequencer;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
    logic       key_pushed = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       out_en;
    logic [3:0] out_code;
    logic [1:0] mode;
    logic [2:0] count;
    logic       full;

    int nchk = 0;
    int nerr = 0;

    note_sequencer #(.DEPTH(4), .DUR_W(3), .TICK_MAX(26'd3)) dut (
        .clk(clk), .nrst(nrst), .rec_start(rec_start), .play_start(play_start),
        .stop(stop), .key_pushed(key_pushed), .key_code(key_code),
        .out_en(out_en), .out_code(out_code), .mode(mode), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       kp;
        logic [3:0] kc;
        logic       rs, ps, sp;
        logic       exp_en;
        logic [3:0] exp_code;
        logic [1:0] exp_mode;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_key(input logic p, input logic [3:0] c);
        key_pushed = p;
        key_code   = c;
    endtask

    task automatic pulse(input logic rs, input logic ps, input logic sp);
        rec_start = rs; play_start = ps; stop = sp;
        @(negedge clk);
        rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    endtask

    // Called one cycle after the last segment has ended.
    task automatic finish_play(input logic live_en, input logic [3:0] live_code,
                               input logic [3:0] seg0_code);
`ifdef NOTE_SEQUENCER_LOOP_EN
        chk("loop_mode", 32'(mode), 32'd2);
        chk("loop_en", 32'(out_en), 32'd1);
        chk("loop_code", 32'(out_code), 32'(seg0_code));
        pulse(1'b0, 1'b0, 1'b1);
        chk("loop_stop_mode", 32'(mode), 32'd0);
`else
        chk("end_mode", 32'(mode), 32'd0);
        chk("end_live_en", 32'(out_en), 32'(live_en));
        if (live_en) chk("end_live_code", 32'(out_code), 32'(live_code));
        chk("end_seg0_unused", 32'(seg0_code != 4'd0 || 1'b1), 32'd1);
`endif
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  2'd0};
        vecs[1] = '{1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 4'd5,  2'd0};
        vecs[2] = '{1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 1'b1, 4'd3,  2'd0};
        vecs[3] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  2'd0};
        vecs[4] = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 2'd0};
        vecs[5] = '{1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 2'd0};

        // Reset state
        set_key(1'b1, 4'd9);
        repeat (2) @(negedge clk);
        chk("rst_en", 32'(out_en), 32'd0);
        chk("rst_code", 32'(out_code), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        nrst = 1'b1;

        // IDLE passthrough and ignored commands with an empty buffer
        for (int i = 0; i < 6; i++) begin
            set_key(vecs[i].kp, vecs[i].kc);
            pulse(vecs[i].rs, vecs[i].ps, vecs[i].sp);
            chk("idle_en", 32'(out_en), 32'(vecs[i].exp_en));
            chk("idle_code", 32'(out_code), 32'(vecs[i].exp_code));
            chk("idle_mode", 32'(mode), 32'(vecs[i].exp_mode));
            chk("idle_count", 32'(count), 32'd0);
        end

        // Record: code 2 for 12 clk, rest 8 clk, code 7 for 8 clk, stop
        set_key(1'b1, 4'd2);
        pulse(1'b1, 1'b0, 1'b0);
        chk("rec_mode", 32'(mode), 32'd1);
        chk("rec_live_code", 32'(out_code), 32'd2);
        repeat (11) @(negedge clk);
        set_key(1'b0, 4'd0);
        repeat (8) @(negedge clk);
        set_key(1'b1, 4'd7);
        repeat (8) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        chk("rec1_mode", 32'(mode), 32'd0);
        chk("rec1_count", 32'(count), 32'd3);
        chk("rec1_full", 32'(full), 32'd0);

        // Playback of the three segments
        set_key(1'b1, 4'd9);
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 28; i++) begin
            logic       e_en;
            logic [3:0] e_code;
            e_en   = (i < 12) || (i >= 20);
            e_code = (i < 12) ? 4'd2 : 4'd7;
            chk("play1_mode", 32'(mode), 32'd2);
            chk("play1_en", 32'(out_en), 32'(e_en));
            if (e_en) chk("play1_code", 32'(out_code), 32'(e_code));
            @(negedge clk);
        end
        finish_play(1'b1, 4'd9, 4'd2);
        chk("play1_count_kept", 32'(count), 32'd3);

        // stop and rec_start together while playing
        set_key(1'b0, 4'd0);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("play2_en", 32'(out_en), 32'd1);
        pulse(1'b1, 1'b0, 1'b1);
        chk("stoprec_mode", 32'(mode), 32'd0);
        chk("stoprec_count", 32'(count), 32'd3);
        chk("stoprec_live", 32'(out_en), 32'd0);

        // Two-cycle key change inside a note is filtered out
        set_key(1'b1, 4'd4);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        set_key(1'b1, 4'd5);
        repeat (2) @(negedge clk);
        set_key(1'b1, 4'd4);
        repeat (5) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        chk("glitch_mode", 32'(mode), 32'd0);
        chk("glitch_count", 32'(count), 32'd2);
        set_key(1'b0, 4'd0);
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("glitch_play_en", 32'(out_en), 32'd1);
            chk("glitch_play_code", 32'(out_code), 32'd4);
            @(negedge clk);
        end
        finish_play(1'b0, 4'd0, 4'd4);

        // Long note splits at max duration; fourth segment fills the buffer
        set_key(1'b1, 4'd1);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (63) @(negedge clk);
        set_key(1'b0, 4'd0);
        @(negedge clk);
        chk("sat_count3", 32'(count), 32'd3);
        chk("sat_mode_rec", 32'(mode), 32'd1);
        repeat (7) @(negedge clk);
        set_key(1'b1, 4'd3);
        @(negedge clk);
        chk("full_mode", 32'(mode), 32'd0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        set_key(1'b0, 4'd0);
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 72; i++) begin
            chk("sat_play_en", 32'(out_en), 32'(i < 64));
            @(negedge clk);
        end
        finish_play(1'b0, 4'd0, 4'd1);
        chk("sat_full_kept", 32'(full), 32'd1);

        // Asynchronous reset in the middle of playback
        set_key(1'b0, 4'd0);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("prerst_en", 32'(out_en), 32'd1);
        #1 nrst = 1'b0;
        #1;
        chk("async_rst_en", 32'(out_en), 32'd0);
        chk("async_rst_mode", 32'(mode), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_full", 32'(full), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        chk("post_rst_play_ignored", 32'(mode), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
